// File: rtl/bopit_pkg.sv
// bopit_pkg: shared button count, button code type and round-robin helper
package bopit_pkg;
  localparam int NUM_BTNS = 5;
  typedef logic [2:0] btn_code_t;
  localparam btn_code_t BTN_0 = 3'd0;
  localparam btn_code_t BTN_1 = 3'd1;
  localparam btn_code_t BTN_2 = 3'd2;
  localparam btn_code_t BTN_3 = 3'd3;
  localparam btn_code_t BTN_4 = 3'd4;
  function automatic btn_code_t rr_next(btn_code_t base, int step);
    int s;
    s = int'(base) + step;
    return btn_code_t'(s % NUM_BTNS);
  endfunction
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: power-of-two event queue with combinational head read
module evt_fifo
  import bopit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  btn_code_t     wdata,
  output btn_code_t     rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  btn_code_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: edge-detect buttons, round-robin grant pending events into a FIFO
module btn_event_arbiter
  import bopit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btns_d,
  input  logic       evt_ready,
  input  logic       clear_ovf,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [4:0] pending,
  output logic [2:0] fifo_count,
  output logic       overflow
);
  logic [4:0] btns_q, rise, gnt_mask;
  logic gnt, hit, pop, space, full, empty, lost;
  btn_code_t last_grant, gnt_idx, cand, head;
  logic [CW-1:0] cnt;
  assign rise     = btns_d & ~btns_q;
  assign pop      = evt_ready & ~empty;
  assign space    = ~full | pop;
  assign gnt      = |pending & space;
  assign gnt_mask = gnt ? 5'b1 << gnt_idx : 5'b0;
  // a rise on a still-pending, ungranted button is merged and reported as lost
  assign lost     = |(rise & pending & ~gnt_mask);
  always_comb begin
    gnt_idx = BTN_0;
    cand    = BTN_0;
    hit     = 1'b0;
    for (int k = 1; k <= NUM_BTNS; k++) begin
      cand = rr_next(last_grant, k);
      if (!hit && pending[cand]) begin
        gnt_idx = cand;
        hit     = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btns_q     <= '0;
      pending    <= '0;
      last_grant <= BTN_4;
      overflow   <= 1'b0;
    end else begin
      btns_q     <= btns_d;
      pending    <= (pending & ~gnt_mask) | rise;
      last_grant <= gnt ? gnt_idx : last_grant;
      overflow   <= lost | (overflow & ~clear_ovf);
    end
  end
  evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt),
    .pop   (pop),
    .wdata (gnt_idx),
    .rdata (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );
  assign evt_valid  = ~empty;
  assign evt_code   = empty ? BTN_0 : head;
  assign fifo_count = 3'(cnt);
endmodule
